// File: rtl/softusb_dmem_arb_pkg.sv
// Shared constants for the softusb data-memory arbiter.
// Starvation counter width and the legal range of its limit.
package softusb_dmem_arb_pkg;

    localparam int wcnt_w = 4;

    typedef logic [wcnt_w-1:0] wcnt_t;

    function automatic bit limit_ok(input int lim);
        return (lim >= 1) && (lim <= (1 << wcnt_w) - 1);
    endfunction

endpackage

// File: rtl/softusb_dmem_arb_if.sv
// Bundle of CPU, DMA and memory-side signals around the dmem arbiter.
// slave is the arbiter view; master is the requester/memory view.
interface softusb_dmem_arb_if #(
    parameter int dmem_width = 13
);
    logic                  cpu_re;
    logic                  cpu_we;
    logic [dmem_width-1:0] cpu_a;
    logic [7:0]            cpu_dw;
    logic [7:0]            cpu_dr;
    logic                  cpu_stall;

    logic                  dma_req;
    logic                  dma_we;
    logic [dmem_width-1:0] dma_a;
    logic [7:0]            dma_dw;
    logic                  dma_ack;
    logic [7:0]            dma_dr;
    logic                  dma_rvalid;

    logic                  mem_we;
    logic [dmem_width-1:0] mem_a;
    logic [7:0]            mem_dw;
    logic [7:0]            mem_dr;

    modport slave (
        input  cpu_re, cpu_we, cpu_a, cpu_dw,
        output cpu_dr, cpu_stall,
        input  dma_req, dma_we, dma_a, dma_dw,
        output dma_ack, dma_dr, dma_rvalid,
        output mem_we, mem_a, mem_dw,
        input  mem_dr
    );

    modport master (
        output cpu_re, cpu_we, cpu_a, cpu_dw,
        input  cpu_dr, cpu_stall,
        output dma_req, dma_we, dma_a, dma_dw,
        input  dma_ack, dma_dr, dma_rvalid,
        input  mem_we, mem_a, mem_dw,
        output mem_dr
    );

endinterface

// File: rtl/softusb_dmem_arb.sv
// Shares the single-port dmem between navre (priority) and the SIE DMA.
// A starvation counter steals one CPU cycle when DMA has waited too long.
module softusb_dmem_arb
    import softusb_dmem_arb_pkg::*;
#(
    parameter int dmem_width   = 13,
    parameter int starve_limit = 7
) (
    input  logic                usb_clk,
    input  logic                usb_rst,
    softusb_dmem_arb_if.slave   bus
);

    generate
        if (!limit_ok(starve_limit)) begin : g_bad_limit
            $error("starve_limit must be within 1..15");
        end
    endgenerate

    localparam wcnt_t limit = wcnt_t'(starve_limit);

    wcnt_t                 wait_cnt;
    logic                  rd_dma;
    logic                  cpu_acc;
    logic                  force_dma;
    logic                  dma_grant;
    logic [dmem_width-1:0] a_sel;

    assign cpu_acc   = bus.cpu_re | bus.cpu_we;
    assign force_dma = bus.dma_req & cpu_acc & (wait_cnt == limit);
    assign dma_grant = bus.dma_req & (~cpu_acc | force_dma);

    // Idle CPU still drives the address; only mem_we distinguishes idle.
    always_comb begin
        a_sel       = bus.cpu_a;
        bus.mem_dw  = bus.cpu_dw;
        bus.mem_we  = bus.cpu_we;
        bus.dma_ack = 1'b0;
        if (dma_grant) begin
            a_sel       = bus.dma_a;
            bus.mem_dw  = bus.dma_dw;
            bus.mem_we  = bus.dma_we;
            bus.dma_ack = 1'b1;
        end
    end

    assign bus.mem_a      = a_sel;
    assign bus.cpu_stall  = force_dma;
    assign bus.cpu_dr     = bus.mem_dr;
    assign bus.dma_dr     = bus.mem_dr;
    assign bus.dma_rvalid = rd_dma;

    always_ff @(posedge usb_clk or posedge usb_rst) begin
        if (usb_rst) begin
            wait_cnt <= '0;
            rd_dma   <= 1'b0;
        end else begin
            rd_dma <= dma_grant & ~bus.dma_we;
            if (!bus.dma_req || dma_grant)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + wcnt_t'(1);
        end
    end

endmodule

// File: tb/tb_softusb_dmem_arb.sv
// Self-checking bench for softusb_dmem_arb with a behavioural dmem.
// DMA read data is checked against a queue of expected bytes.
module tb_softusb_dmem_arb;

    localparam int aw = 13;
    localparam int sl = 7;

    logic usb_clk = 1'b0;
    logic usb_rst;

    softusb_dmem_arb_if #(.dmem_width(aw)) bus ();

    softusb_dmem_arb #(
        .dmem_width  (aw),
        .starve_limit(sl)
    ) dut (
        .usb_clk(usb_clk),
        .usb_rst(usb_rst),
        .bus    (bus)
    );

    always #5 usb_clk = ~usb_clk;

    logic [7:0] mem [0:(1<<aw)-1];

    always @(posedge usb_clk) begin
        if (bus.mem_we)
            mem[bus.mem_a] <= bus.mem_dw;
        bus.mem_dr <= mem[bus.mem_a];
    end

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge usb_clk) begin
        if (!usb_rst && bus.dma_rvalid) begin
            if (exp_q.size() == 0)
                chk("rvalid_extra", 1, 0);
            else
                chk("dma_dr", {24'd0, bus.dma_dr}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic idle();
        bus.cpu_re  = 1'b0;
        bus.cpu_we  = 1'b0;
        bus.cpu_a   = '0;
        bus.cpu_dw  = '0;
        bus.dma_req = 1'b0;
        bus.dma_we  = 1'b0;
        bus.dma_a   = '0;
        bus.dma_dw  = '0;
    endtask

    task automatic dma(input logic we, input logic [aw-1:0] a,
                       input logic [7:0] dw);
        bus.dma_req = 1'b1;
        bus.dma_we  = we;
        bus.dma_a   = a;
        bus.dma_dw  = dw;
    endtask

    initial begin
        for (int i = 0; i < (1 << aw); i++)
            mem[i] = 8'h00;
        for (int i = 0; i < 4; i++)
            mem[13'h200 + i] = 8'(i + 1);
        bus.mem_dr = '0;
        idle();
        usb_rst = 1'b1;

        // reset state
        @(negedge usb_clk);
        chk("rst_rvalid", bus.dma_rvalid, 0);
        chk("rst_stall",  bus.cpu_stall,  0);
        chk("rst_ack",    bus.dma_ack,    0);
        chk("rst_mem_we", bus.mem_we,     0);
        tick();
        usb_rst = 1'b0;
        tick();

        // 1: DMA write then read back with idle CPU
        dma(1'b1, 13'h100, 8'hA5);
        @(negedge usb_clk);
        chk("t1_wr_ack", bus.dma_ack, 1);
        chk("t1_wr_we",  bus.mem_we,  1);
        chk("t1_wr_a",   bus.mem_a,   13'h100);
        tick();
        dma(1'b0, 13'h100, 8'h00);
        exp_q.push_back(8'hA5);
        @(negedge usb_clk);
        chk("t1_rd_ack", bus.dma_ack, 1);
        chk("t1_rd_we",  bus.mem_we,  0);
        tick();
        idle();
        @(negedge usb_clk);
        chk("t1_rvalid", bus.dma_rvalid, 1);
        tick();

        // 2: starvation with CPU reading every cycle
        bus.cpu_re = 1'b1;
        bus.cpu_a  = 13'h010;
        dma(1'b0, 13'h101, 8'h00);
        for (int i = 0; i < sl; i++) begin
            @(negedge usb_clk);
            chk("t2_refuse_ack",   bus.dma_ack,   0);
            chk("t2_refuse_stall", bus.cpu_stall, 0);
            chk("t2_refuse_a",     bus.mem_a,     13'h010);
            tick();
        end
        exp_q.push_back(8'h00);
        @(negedge usb_clk);
        chk("t2_force_ack",   bus.dma_ack,   1);
        chk("t2_force_stall", bus.cpu_stall, 1);
        chk("t2_force_a",     bus.mem_a,     13'h101);
        tick();
        bus.dma_req = 1'b0;
        @(negedge usb_clk);
        chk("t2_after_stall", bus.cpu_stall, 0);
        chk("t2_after_a",     bus.mem_a,     13'h010);
        tick();
        idle();
        tick();

        // 3: same-address CPU and DMA writes
        bus.cpu_we = 1'b1;
        bus.cpu_a  = 13'h040;
        bus.cpu_dw = 8'h11;
        dma(1'b1, 13'h040, 8'h22);
        @(negedge usb_clk);
        chk("t3_cpu_ack",   bus.dma_ack,   0);
        chk("t3_cpu_stall", bus.cpu_stall, 0);
        chk("t3_cpu_dw",    bus.mem_dw,    8'h11);
        chk("t3_cpu_we",    bus.mem_we,    1);
        tick();
        bus.cpu_we = 1'b0;
        @(negedge usb_clk);
        chk("t3_dma_ack", bus.dma_ack, 1);
        chk("t3_dma_dw",  bus.mem_dw,  8'h22);
        tick();
        dma(1'b0, 13'h040, 8'h00);
        exp_q.push_back(8'h22);
        @(negedge usb_clk);
        chk("t3_rd_ack", bus.dma_ack, 1);
        tick();
        idle();
        bus.cpu_re = 1'b1;
        bus.cpu_a  = 13'h040;
        tick();
        bus.cpu_re = 1'b0;
        @(negedge usb_clk);
        chk("t3_cpu_dr", bus.cpu_dr, 8'h22);
        tick();

        // 4: back-to-back DMA read burst
        for (int i = 0; i < 4; i++) begin
            dma(1'b0, 13'(13'h200 + i), 8'h00);
            exp_q.push_back(8'(i + 1));
            @(negedge usb_clk);
            chk("t4_ack", bus.dma_ack, 1);
            if (i > 0)
                chk("t4_rvalid", bus.dma_rvalid, 1);
            tick();
        end
        idle();
        @(negedge usb_clk);
        chk("t4_rvalid_last", bus.dma_rvalid, 1);
        tick();
        @(negedge usb_clk);
        chk("t4_rvalid_end", bus.dma_rvalid, 0);
        tick();

        // 5: reset lands on an in-flight DMA read
        dma(1'b0, 13'h201, 8'h00);
        @(negedge usb_clk);
        chk("t5_ack", bus.dma_ack, 1);
        tick();
        usb_rst    = 1'b1;
        bus.cpu_re = 1'b1;
        bus.cpu_a  = 13'h020;
        #1;
        chk("t5_rst_rvalid", bus.dma_rvalid, 0);
        for (int i = 0; i < 3; i++)
            tick();
        usb_rst = 1'b0;
        for (int i = 0; i < sl - 1; i++) begin
            @(negedge usb_clk);
            chk("t5_post_ack",   bus.dma_ack,   0);
            chk("t5_post_stall", bus.cpu_stall, 0);
            tick();
        end
        bus.cpu_re = 1'b0;
        exp_q.push_back(8'h02);
        @(negedge usb_clk);
        chk("t5_idle_ack", bus.dma_ack, 1);
        tick();
        idle();
        tick();
        tick();

        chk("rd_pending", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
